usb_bus_master: RTL and testbench

- Initiator end of the CW-Lite FPGA/USB-controller parallel register bus. Sequences ALEn, CEn, RDn and WRn strobes, the 8-bit address and the 8-bit data bus.
- Takes single- or burst-length register read/write commands from a simple valid/ready front end.
- Used as the host-side bus model in system benches, and as the on-chip master wherever FPGA logic must drive an openadc_interface-style responder directly.

---
 rtl/usb_bus_master.sv | 165 ++++++++++++++++
 tb/tb_usb_bus_master.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_master.sv
// Initiator for the CW-Lite FPGA/USB-controller parallel register bus.
// One address phase per burst, then SETUP/(DRIVE)/STROBE/HOLD per byte, then TURN.
module usb_bus_master #(
    parameter int unsigned ALE_CYC    = 2,
    parameter int unsigned STROBE_CYC = 3,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned TURN_CYC   = 2
) (
    input  logic        clk_usb,
    input  logic        reset_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [7:0]  cmd_addr,
    input  logic [15:0] cmd_len,
    input  logic [7:0]  wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic [7:0]  usb_addr_o,
    output logic [7:0]  usb_d_o,
    output logic        usb_d_oe,
    input  logic [7:0]  usb_d_i,
    output logic        usb_alen_o,
    output logic        usb_cen_o,
    output logic        usb_rdn_o,
    output logic        usb_wrn_o
);
    localparam int unsigned CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ALE,
        S_SETUP,
        S_DRIVE,
        S_STROBE,
        S_HOLD,
        S_TURN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] remain;
    logic             is_write;
    logic             last_phase;

    // phase_cnt counts down the cycles left in a multi-cycle state
    assign last_phase = (phase_cnt == '0);

    // Outputs are assigned on the transition into each state so they are valid for its whole span
    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state      <= S_IDLE;
            phase_cnt  <= '0;
            remain     <= '0;
            is_write   <= 1'b0;
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            wr_ready   <= 1'b0;
            usb_addr_o <= '0;
            usb_d_o    <= '0;
            usb_d_oe   <= 1'b0;
            usb_alen_o <= 1'b1;
            usb_cen_o  <= 1'b1;
            usb_rdn_o  <= 1'b1;
            usb_wrn_o  <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        is_write   <= cmd_write;
                        usb_addr_o <= cmd_addr;
                        remain     <= (cmd_len == '0) ? CNT_W'(1) : cmd_len;
                        phase_cnt  <= CNT_W'(ALE_CYC - 1);
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        usb_alen_o <= 1'b0;
                        state      <= S_ALE;
                    end
                end
                S_ALE: begin
                    if (last_phase) begin
                        usb_alen_o <= 1'b1;
                        usb_cen_o  <= 1'b0;
                        wr_ready   <= is_write;
                        state      <= S_SETUP;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                S_SETUP: begin
                    if (is_write) begin
                        // stall indefinitely until the front end supplies a byte
                        if (wr_valid) begin
                            usb_d_o  <= wr_data;
                            usb_d_oe <= 1'b1;
                            wr_ready <= 1'b0;
                            state    <= S_DRIVE;
                        end
                    end else begin
                        usb_rdn_o <= 1'b0;
                        phase_cnt <= CNT_W'(STROBE_CYC - 1);
                        state     <= S_STROBE;
                    end
                end
                S_DRIVE: begin
                    usb_wrn_o <= 1'b0;
                    phase_cnt <= CNT_W'(STROBE_CYC - 1);
                    state     <= S_STROBE;
                end
                S_STROBE: begin
                    if (last_phase) begin
                        usb_rdn_o <= 1'b1;
                        usb_wrn_o <= 1'b1;
                        phase_cnt <= CNT_W'(HOLD_CYC - 1);
                        if (!is_write) begin
                            rd_data  <= usb_d_i;
                            rd_valid <= 1'b1;
                        end
                        state <= S_HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (last_phase) begin
                        remain   <= remain - CNT_W'(1);
                        usb_d_oe <= 1'b0;
                        if (remain != CNT_W'(1)) begin
                            wr_ready <= is_write;
                            state    <= S_SETUP;
                        end else begin
                            usb_cen_o <= 1'b1;
                            phase_cnt <= CNT_W'(TURN_CYC - 1);
                            done      <= (TURN_CYC == 1);
                            state     <= S_TURN;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                    end
                end
                S_TURN: begin
                    if (last_phase) begin
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - CNT_W'(1);
                        done      <= (phase_cnt == CNT_W'(1));
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bus_master.sv
// Self-checking bench for usb_bus_master: cycle-exact write, vector table, reset abort, back-to-back.
`timescale 1ns/1ps
module tb_usb_bus_master;
    logic        clk_usb = 1'b0;
    logic        reset_i;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [7:0]  cmd_addr;
    logic [15:0] cmd_len;
    logic [7:0]  wr_data;
    logic        wr_valid, wr_ready;
    logic [7:0]  rd_data;
    logic        rd_valid, busy, done;
    logic [7:0]  usb_addr_o, usb_d_o, usb_d_i;
    logic        usb_d_oe, usb_alen_o, usb_cen_o, usb_rdn_o, usb_wrn_o;

    // second instance with other timing parameters, random traffic, protocol checks only
    logic        alt_cmd_valid, alt_cmd_ready, alt_cmd_write;
    logic [7:0]  alt_cmd_addr;
    logic [15:0] alt_cmd_len;
    logic [7:0]  alt_wr_data, alt_rd_data, alt_addr, alt_d_o, alt_d_i;
    logic        alt_wr_valid, alt_wr_ready, alt_rd_valid, alt_busy, alt_done;
    logic        alt_d_oe, alt_alen, alt_cen, alt_rdn, alt_wrn;

    always #5 clk_usb = ~clk_usb;

    usb_bus_master #(.ALE_CYC(2), .STROBE_CYC(3), .HOLD_CYC(1), .TURN_CYC(2)) dut (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
        .usb_addr_o(usb_addr_o), .usb_d_o(usb_d_o), .usb_d_oe(usb_d_oe), .usb_d_i(usb_d_i),
        .usb_alen_o(usb_alen_o), .usb_cen_o(usb_cen_o), .usb_rdn_o(usb_rdn_o), .usb_wrn_o(usb_wrn_o)
    );

    usb_bus_master #(.ALE_CYC(1), .STROBE_CYC(4), .HOLD_CYC(2), .TURN_CYC(1)) u_alt (
        .clk_usb(clk_usb), .reset_i(reset_i),
        .cmd_valid(alt_cmd_valid), .cmd_ready(alt_cmd_ready), .cmd_write(alt_cmd_write),
        .cmd_addr(alt_cmd_addr), .cmd_len(alt_cmd_len),
        .wr_data(alt_wr_data), .wr_valid(alt_wr_valid), .wr_ready(alt_wr_ready),
        .rd_data(alt_rd_data), .rd_valid(alt_rd_valid), .busy(alt_busy), .done(alt_done),
        .usb_addr_o(alt_addr), .usb_d_o(alt_d_o), .usb_d_oe(alt_d_oe), .usb_d_i(alt_d_i),
        .usb_alen_o(alt_alen), .usb_cen_o(alt_cen), .usb_rdn_o(alt_rdn), .usb_wrn_o(alt_wrn)
    );

    // ---------------- responder / bus monitor ----------------
    logic [7:0]  rd_base;
    logic [7:0]  resp_ptr = '0;
    logic        prev_alen = 1'b1, prev_rdn = 1'b1, prev_wrn = 1'b1;
    int unsigned cyc = 0, alen_falls = 0, rdn_pulses = 0, wrn_pulses = 0;
    int unsigned done_cnt = 0, rdv_cnt = 0, oe_cyc = 0, viol = 0;
    int unsigned alen_fall_cyc = 0, rdn_fall_cyc = 0, rdn_gap = 0, done_cyc = 0;
    int unsigned rdn_low_run = 0, rdn_low_len = 0;
    int unsigned alt_viol = 0, alt_done_cnt = 0;
    logic [7:0]  ale_addr = '0;
    logic [7:0]  obs_rd[$], obs_wr[$], exp_q[$];

    assign usb_d_i = rd_base + resp_ptr;

    always @(negedge clk_usb) begin
        cyc       <= cyc + 1;
        prev_alen <= usb_alen_o;
        prev_rdn  <= usb_rdn_o;
        prev_wrn  <= usb_wrn_o;
        if (!usb_alen_o && prev_alen) begin
            alen_falls    <= alen_falls + 1;
            alen_fall_cyc <= cyc;
            ale_addr      <= usb_addr_o;
            resp_ptr      <= '0;
        end
        if (!usb_rdn_o && prev_rdn) begin
            rdn_gap      <= cyc - rdn_fall_cyc;
            rdn_fall_cyc <= cyc;
        end
        if (!usb_rdn_o) rdn_low_run <= prev_rdn ? 1 : rdn_low_run + 1;
        if (usb_rdn_o && !prev_rdn) begin
            rdn_pulses  <= rdn_pulses + 1;
            rdn_low_len <= rdn_low_run;
            resp_ptr    <= resp_ptr + 8'd1;
        end
        if (usb_wrn_o && !prev_wrn) begin
            wrn_pulses <= wrn_pulses + 1;
            obs_wr.push_back(usb_d_o);
        end
        if (rd_valid) begin
            rdv_cnt <= rdv_cnt + 1;
            obs_rd.push_back(rd_data);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (usb_d_oe) oe_cyc <= oe_cyc + 1;
        if ((!usb_rdn_o && !usb_wrn_o) || (usb_d_oe && !usb_rdn_o) || (!usb_wrn_o && !usb_d_oe))
            viol <= viol + 1;
        if ((!alt_rdn && !alt_wrn) || (alt_d_oe && !alt_rdn)) alt_viol <= alt_viol + 1;
        if (alt_done) alt_done_cnt <= alt_done_cnt + 1;
    end

    initial begin
        alt_cmd_valid = 0; alt_cmd_write = 0; alt_cmd_addr = '0; alt_cmd_len = '0;
        alt_wr_data = '0; alt_wr_valid = 0; alt_d_i = '0;
        forever begin
            @(negedge clk_usb); #1;
            alt_cmd_valid = 1'($urandom_range(0, 1));
            alt_cmd_write = 1'($urandom_range(0, 1));
            alt_cmd_addr  = 8'($urandom);
            alt_cmd_len   = 16'($urandom_range(0, 3));
            alt_wr_data   = 8'($urandom);
            alt_wr_valid  = ($urandom_range(0, 3) != 0);
            alt_d_i       = 8'($urandom);
        end
    end

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [15:0] len;
        logic [7:0]  base;
        int          stall_idx;
        int          stall_cyc;
        int          exp_n;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int unsigned a0, r0, w0, d0, o0, rv0;
        int          idx, stalled, budget;
        logic        accepted;
        logic [7:0]  e, o;
        exp_q.delete(); obs_rd.delete(); obs_wr.delete();
        for (int i = 0; i < v.exp_n; i++) exp_q.push_back(8'(v.base + 8'(i)));
        rd_base = v.base;
        a0 = alen_falls; r0 = rdn_pulses; w0 = wrn_pulses; d0 = done_cnt; o0 = oe_cyc; rv0 = rdv_cnt;
        idx = 0; stalled = 0; accepted = 1'b0; budget = 0;
        cmd_write = v.write; cmd_addr = v.addr; cmd_len = v.len;
        while (budget < 2000) begin
            @(negedge clk_usb); #1;
            budget++;
            if (done_cnt != d0) break;
            cmd_valid = !accepted;
            if (cmd_valid && cmd_ready) accepted = 1'b1;
            if (v.write && idx == v.stall_idx && stalled < v.stall_cyc && wr_ready) begin
                wr_valid = 1'b0;
                chk("stall_cen", 32'(usb_cen_o), 0);
                chk("stall_wrn", 32'(usb_wrn_o), 1);
                stalled++;
            end else begin
                wr_valid = v.write && (idx < v.exp_n);
            end
            wr_data = 8'(v.base + 8'(idx));
            if (wr_valid && wr_ready) idx++;
        end
        cmd_valid = 1'b0;
        wr_valid  = 1'b0;
        chk("done_count", done_cnt - d0, 1);
        chk("ale_pulses", alen_falls - a0, 1);
        chk("ale_addr", 32'(ale_addr), 32'(v.addr));
        chk("stall_cycles", stalled, v.write ? v.stall_cyc : 0);
        if (v.write) begin
            chk("wrn_pulses", wrn_pulses - w0, v.exp_n);
            chk("rdn_pulses", rdn_pulses - r0, 0);
            chk("oe_cycles", oe_cyc - o0, 5 * v.exp_n);
            chk("wr_count", 32'(obs_wr.size()), v.exp_n);
        end else begin
            chk("rdn_pulses", rdn_pulses - r0, v.exp_n);
            chk("wrn_pulses", wrn_pulses - w0, 0);
            chk("oe_cycles", oe_cyc - o0, 0);
            chk("rdv_count", rdv_cnt - rv0, v.exp_n);
            chk("rdn_low_len", rdn_low_len, 3);
            if (v.exp_n > 1) chk("rdn_spacing", rdn_gap, 5);
            chk("rd_count", 32'(obs_rd.size()), v.exp_n);
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (v.write) o = (obs_wr.size() != 0) ? obs_wr.pop_front() : 8'hxx;
            else         o = (obs_rd.size() != 0) ? obs_rd.pop_front() : 8'hxx;
            chk(v.write ? "wr_byte" : "rd_byte", 32'(o), 32'(e));
        end
    endtask

    logic [6:0]  pat [1:11];
    int unsigned d0, a0, d1;
    int          budget;
    logic        seen_first, checked;

    initial begin
        reset_i = 1'b1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_len = '0;
        wr_data = '0; wr_valid = 0; rd_base = '0;
        // {alen, cen, wrn, oe, done, cmd_ready, wr_ready} for T1..T11 of a single default write
        pat[1] = 7'b0110000; pat[2] = 7'b0110000; pat[3] = 7'b1010001; pat[4] = 7'b1011000;
        pat[5] = 7'b1001000; pat[6] = 7'b1001000; pat[7] = 7'b1001000; pat[8] = 7'b1011000;
        pat[9] = 7'b1110000; pat[10] = 7'b1110100; pat[11] = 7'b1110010;
        vecs[0] = '{1'b0, 8'h03, 16'd4, 8'h10, -1, 0, 4};
        vecs[1] = '{1'b1, 8'h20, 16'd3, 8'h40,  1, 4, 3};
        vecs[2] = '{1'b0, 8'h07, 16'd0, 8'h77, -1, 0, 1};
        vecs[3] = '{1'b1, 8'h81, 16'd2, 8'hC0, -1, 0, 2};
        vecs[4] = '{1'b0, 8'hFF, 16'd5, 8'hF0, -1, 0, 5};
        vecs[5] = '{1'b1, 8'h00, 16'd0, 8'h3C, -1, 0, 1};

        repeat (3) @(negedge clk_usb);
        #1;
        chk("reset_ctrl", 32'({usb_alen_o, usb_cen_o, usb_rdn_o, usb_wrn_o, usb_d_oe,
                              cmd_ready, busy, done, rd_valid, wr_ready}), 32'(10'b1111010000));
        chk("reset_data", 32'({usb_addr_o, usb_d_o, rd_data}), 0);
        reset_i = 1'b0;

        // cycle-exact single write
        @(negedge clk_usb); #1;
        cmd_valid = 1; cmd_write = 1; cmd_addr = 8'h05; cmd_len = 16'd1; wr_valid = 1; wr_data = 8'hA5;
        chk("t1_ready_T0", 32'(cmd_ready), 1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk_usb); #1;
            cmd_valid = 0;
            chk($sformatf("t1_pattern_T%0d", c),
                32'({usb_alen_o, usb_cen_o, usb_wrn_o, usb_d_oe, done, cmd_ready, wr_ready}),
                32'(pat[c]));
            if (c == 1) chk("t1_addr", 32'(usb_addr_o), 32'h05);
            if (c == 4) chk("t1_data", 32'(usb_d_o), 32'hA5);
        end
        wr_valid = 0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // reset during the second WRn-low cycle
        cmd_write = 1; cmd_addr = 8'h30; cmd_len = 16'd3; wr_valid = 1; wr_data = 8'h55; cmd_valid = 1;
        budget = 0;
        while (budget < 200) begin
            @(negedge clk_usb); #1;
            budget++;
            if (!cmd_ready) cmd_valid = 0;
            if (!usb_wrn_o) break;
        end
        chk("rst_wrn_seen", 32'(usb_wrn_o), 0);
        @(negedge clk_usb); #1;
        chk("rst_wrn_2nd", 32'(usb_wrn_o), 0);
        reset_i = 1'b1;
        #1;
        chk("rst_async", 32'({usb_wrn_o, usb_cen_o, usb_alen_o, usb_rdn_o, usb_d_oe}), 32'(5'b11110));
        @(negedge clk_usb); #1;
        reset_i = 1'b0; wr_valid = 0;
        @(negedge clk_usb); #1;
        chk("rst_idle", 32'({cmd_ready, busy, done}), 32'(3'b100));
        run_vec('{1'b1, 8'h31, 16'd2, 8'h9A, -1, 0, 2});

        // back-to-back reads with cmd_valid held high
        exp_q.delete(); obs_rd.delete();
        rd_base = 8'h60; cmd_write = 0; cmd_addr = 8'h44; cmd_len = 16'd1; cmd_valid = 1;
        d0 = done_cnt; a0 = alen_falls; d1 = 0; seen_first = 0; checked = 0; budget = 0;
        while (budget < 200) begin
            @(negedge clk_usb); #1;
            budget++;
            if (seen_first && !checked) begin
                chk("b2b_ready_after_done", 32'(cmd_ready), 1);
                checked = 1;
            end
            if (done_cnt - d0 == 1 && !seen_first) begin
                seen_first = 1;
                d1 = done_cyc;
            end
            if (done_cnt - d0 >= 2) break;
        end
        cmd_valid = 0;
        chk("b2b_dones", done_cnt - d0, 2);
        chk("b2b_ale_pulses", alen_falls - a0, 2);
        chk("b2b_restart_gap", alen_fall_cyc - d1, 2);
        chk("b2b_rd_count", 32'(obs_rd.size()), 2);
        while (obs_rd.size() != 0) chk("b2b_rd_byte", 32'(obs_rd.pop_front()), 32'h60);

        repeat (4) @(negedge clk_usb);
        #1;
        chk("protocol_violations", viol, 0);
        chk("alt_protocol_violations", alt_viol, 0);
        chk("alt_done_seen", 32'(alt_done_cnt != 0), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
